// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 8-digit hex driver for a common-anode seven-segment display.
// Latency: data_in/dp_mask are snapshotted on the frame-wrap edge and shown on that same edge (registered outputs).
// Backpressure: none; free-running scan, and input changes between wraps are ignored until the next frame.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset; forces all outputs dark immediately
//   data_in  - 32-bit value to show; nibble k drives digit k (digit 0 rightmost)
//   dp_mask  - decimal-point enables; bit k lights the DP of digit k
//   an_n     - digit anodes, active-low, bit k = digit k
//   seg_n    - segment cathodes, active-low, order gfedcba (seg_n[6] = g)
//   dp_n     - decimal-point cathode, active-low
//
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking (digit 0 is never blanked).

module seg_scan #(
  parameter int SCAN_DIV = 100000,  // clock cycles per digit slot, >= 2
  parameter int DEAD_CYC = 16       // anode-off cycles at slot start, 0 <= DEAD_CYC < SCAN_DIV
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt, div_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [31:0]      frame, frame_nxt;
  logic [7:0]       frame_dp, frame_dp_nxt;
  // Held low from reset until the first frame wrap so the display stays dark
  // during the partial slot that precedes the first capture.
  logic             live, live_nxt;

  logic             tick;
  logic             wrap;
  logic             in_dead;
  logic             blank;
  logic [3:0]       nib;
  logic [7:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot counter, digit index and snapshot next-state.
  always_comb begin
    tick         = (div_cnt == DIV_LAST);
    div_nxt      = tick ? '0 : div_cnt + CNT_W'(1);
    idx_nxt      = tick ? idx + 3'd1 : idx;
    wrap         = tick && (idx == 3'd7);
    live_nxt     = live | wrap;
    frame_nxt    = wrap ? data_in : frame;
    frame_dp_nxt = wrap ? dp_mask : frame_dp;
    nib          = frame_nxt[{idx_nxt, 2'b00} +: 4];
  end

  // Dead phase is judged on the counter value being loaded, so the anode
  // drops on the tick edge and returns on the edge where div_cnt becomes DEAD_CYC.
  generate
    if (DEAD_CYC > 0) begin : g_dead
      assign in_dead = (div_nxt < CNT_W'(DEAD_CYC));
    end else begin : g_no_dead
      assign in_dead = 1'b0;
    end
  endgenerate

`ifdef SEG_LZ_BLANK_EN
  // Digit k blanks when nibbles k..7 are all zero, i.e. nothing remains after
  // shifting the digit down to bit 0.
  logic [31:0] upper;
  always_comb begin
    upper = frame_nxt >> {idx_nxt, 2'b00};
    blank = (idx_nxt != 3'd0) && (upper == 32'd0);
  end
`else
  assign blank = 1'b0;
`endif

  // Output next-state, computed entirely from next-state slot values so every
  // register moves together on the same edge.
  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (live_nxt) begin
      if (!in_dead) begin
        an_nxt = ~(8'h01 << idx_nxt);
      end
      if (!blank) begin
        seg_nxt = hex_decode(nib);
        dp_nxt  = ~frame_dp_nxt[idx_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      idx      <= 3'd7;
      frame    <= 32'd0;
      frame_dp <= 8'd0;
      live     <= 1'b0;
      an_n     <= 8'hFF;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      div_cnt  <= div_nxt;
      idx      <= idx_nxt;
      frame    <= frame_nxt;
      frame_dp <= frame_dp_nxt;
      live     <= live_nxt;
      an_n     <= an_nxt;
      seg_n    <= seg_nxt;
      dp_n     <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

  localparam int SD = 4;  // main instance: SCAN_DIV
  localparam int DC = 1;  // main instance: DEAD_CYC

`ifdef SEG_LZ_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  // Expected pattern for a leading-zero digit position.
  localparam logic [6:0] Z = BLANK ? 7'h7F : 7'h40;

  typedef struct packed {
    logic [31:0]     data;
    logic [7:0]      dp;
    logic [7:0][6:0] seg;  // seg[k] = expected seg_n of digit k
    logic [7:0]      dpn;  // dpn[k] = expected dp_n of digit k
  } vec_t;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic [7:0]  dp_mask;
  logic [7:0]  an_n, an_dt;
  logic [6:0]  seg_n, seg_dt;
  logic        dp_n, dp_dt;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t exp_q[$];
  exp_t e;
  bit   mon_en    = 1'b1;
  bit   prev_dark = 1'b1;
  vec_t tbl[5];

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .dp_mask(dp_mask),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  seg_scan #(.SCAN_DIV(8), .DEAD_CYC(3)) u_dt (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .dp_mask(dp_mask),
    .an_n(an_dt), .seg_n(seg_dt), .dp_n(dp_dt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0][6:0] seg, input logic [7:0] dpn, input int ndig);
    logic [7:0] a;
    exp_t x;
    for (int k = 0; k < ndig; k++) begin
      a = 8'h01 << k;
      x.an  = ~a;
      x.seg = seg[k];
      x.dp  = dpn[k];
      exp_q.push_back(x);
    end
  endtask

  task automatic dark_after_release(input string name);
    check(name, {16'd0, an_n, seg_n, dp_n}, {16'd0, 8'hFF, 7'h7F, 1'b1});
    for (int k = 1; k < SD; k++) begin
      @(posedge clk);
      @(negedge clk);
      check(name, {16'd0, an_n, seg_n, dp_n}, {16'd0, 8'hFF, 7'h7F, 1'b1});
    end
  endtask

  // Scoreboard monitor: each time an anode comes on after a dark cycle a new
  // digit is being shown; it must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_dark = 1'b1;
    end else begin
      if (mon_en && an_n != 8'hFF && prev_dark) begin
        if (exp_q.size() == 0) begin
          check("unexpected_digit", {16'd0, an_n, seg_n, dp_n}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("scan_an%h", e.an), {16'd0, an_n, seg_n, dp_n}, {16'd0, e});
        end
      end
      prev_dark = (an_n == 8'hFF);
    end
  end

  // Dead-time instance: 7 dark edges, then per slot 3 dark edges and 5 active.
  initial begin
    logic [7:0] want;
    @(posedge reset_n);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("dt_pre", {24'd0, an_dt}, 32'h0000_00FF);
    end
    for (int j = 0; j < 8; j++) begin
      for (int m = 0; m < 8; m++) begin
        @(posedge clk);
        @(negedge clk);
        want = 8'h01 << j;
        want = (m < 3) ? 8'hFF : ~want;
        check($sformatf("dt_d%0d_c%0d", j, m), {24'd0, an_dt}, {24'd0, want});
      end
    end
  end

  initial begin
    tbl[0] = '{32'h12345678, 8'h01,
               {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hFE};
    tbl[1] = '{32'h00000000, 8'h00,
               {Z, Z, Z, Z, Z, Z, Z, 7'h40}, 8'hFF};
    tbl[2] = '{32'hFFFFFFFF, 8'h80,
               {8{7'h0E}}, 8'h7F};
    tbl[3] = '{32'h000000A5, 8'hFF,
               {Z, Z, Z, Z, Z, Z, 7'h08, 7'h12}, BLANK ? 8'hFC : 8'h00};
    tbl[4] = '{32'h9ABCDEF0, 8'hFF,
               {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}, 8'h00};

    reset_n = 1'b0;
    data_in = tbl[0].data;
    dp_mask = tbl[0].dp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", {16'd0, an_n, seg_n, dp_n}, {16'd0, 8'hFF, 7'h7F, 1'b1});
    push_frame(tbl[0].seg, tbl[0].dpn, 8);
    reset_n = 1'b1;
    dark_after_release("reset_dark");
    @(posedge clk);  // first tick: wrap, captures tbl[0]

    // Each new value is applied while digit 3 of the current frame is shown,
    // so it must not appear before the next wrap.
    for (int v = 1; v < 5; v++) begin
      repeat (3 * SD) @(posedge clk);
      @(negedge clk);
      data_in = tbl[v].data;
      dp_mask = tbl[v].dp;
      push_frame(tbl[v].seg, tbl[v].dpn, 8);
      repeat (5 * SD) @(posedge clk);
    end

    // tbl[4] stays on the inputs and is recaptured; reset arrives during digit 5.
    repeat (3 * SD) @(posedge clk);
    @(negedge clk);
    push_frame(tbl[4].seg, tbl[4].dpn, 5);
    repeat (5 * SD) @(posedge clk);
    repeat (5 * SD + 1) @(posedge clk);
    #2;
    check("pre_reset_an", {24'd0, an_n}, 32'h0000_00DF);
    reset_n = 1'b0;
    #1;
    check("async_dark", {16'd0, an_n, seg_n, dp_n}, {16'd0, 8'hFF, 7'h7F, 1'b1});
    data_in = 32'h00C0FFEE;
    dp_mask = 8'h00;
    push_frame({Z, Z, 7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06}, 8'hFF, 8);
    reset_n = 1'b1;
    dark_after_release("midreset_dark");
    @(posedge clk);  // fresh wrap
    repeat (8 * SD) @(posedge clk);
    #1;
    mon_en = 1'b0;
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
